// File: rtl/seven_segment_pkg.sv
// Shared glyphs, digit-index type and enable constants for the seven-segment scanner.
// Segment order is {dp,g,f,e,d,c,b,a}, active-low.
package seven_segment_pkg;

   localparam int unsigned SEG_W   = 8;
   localparam int unsigned EN_W    = 4;
   localparam int unsigned VALUE_W = 8;
   localparam int unsigned NIB_W   = 4;

   localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
   localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
   localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
   localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
   localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
   localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
   localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
   localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
   localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
   localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
   localparam logic [SEG_W-1:0] SEG_A     = 8'h88;
   localparam logic [SEG_W-1:0] SEG_B     = 8'h83;
   localparam logic [SEG_W-1:0] SEG_C     = 8'hC6;
   localparam logic [SEG_W-1:0] SEG_D     = 8'hA1;
   localparam logic [SEG_W-1:0] SEG_E     = 8'h86;
   localparam logic [SEG_W-1:0] SEG_F     = 8'h8E;
   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

   localparam logic [EN_W-1:0]  ALL_OFF   = 4'hF;

   typedef logic [1:0] digit_idx_t;

   typedef enum logic [1:0] {
      BCD_IDLE,
      BCD_SHIFT,
      BCD_DONE
   } bcd_state_t;

   // Hex glyph for one nibble; b and d are lowercase.
   function automatic logic [SEG_W-1:0] seg_glyph(input logic [NIB_W-1:0] nib);
      logic [SEG_W-1:0] g;
      case (nib)
         4'h0:    g = SEG_0;
         4'h1:    g = SEG_1;
         4'h2:    g = SEG_2;
         4'h3:    g = SEG_3;
         4'h4:    g = SEG_4;
         4'h5:    g = SEG_5;
         4'h6:    g = SEG_6;
         4'h7:    g = SEG_7;
         4'h8:    g = SEG_8;
         4'h9:    g = SEG_9;
         4'hA:    g = SEG_A;
         4'hB:    g = SEG_B;
         4'hC:    g = SEG_C;
         4'hD:    g = SEG_D;
         4'hE:    g = SEG_E;
         default: g = SEG_F;
      endcase
      return g;
   endfunction

   // Active-low one-cold enable; bit 0 is the rightmost digit.
   function automatic logic [EN_W-1:0] digit_enable(input digit_idx_t idx);
      logic [EN_W-1:0] e;
      case (idx)
         2'd0:    e = 4'b1110;
         2'd1:    e = 4'b1101;
         2'd2:    e = 4'b1011;
         default: e = 4'b0111;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/binary_to_bcd.sv
// Iterative double-dabble: 8 shift cycles then a done cycle; done stays high until the next start.
// Only built when SEVEN_SEGMENT_BCD_EN is defined.
`ifdef SEVEN_SEGMENT_BCD_EN
module binary_to_bcd
   import seven_segment_pkg::*;
(
   input  logic               clock,
   input  logic               resetN,
   input  logic               start,
   input  logic [VALUE_W-1:0] binary,
   output logic               done,
   output logic [NIB_W-1:0]   ones,
   output logic [NIB_W-1:0]   tens,
   output logic [NIB_W-1:0]   hundreds
);

   localparam int unsigned BCD_W = 3 * NIB_W;
   localparam int unsigned CNT_W = 3;

   bcd_state_t         r_state;
   bcd_state_t         w_state_nxt;
   logic [VALUE_W-1:0] r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_done;
   logic               w_load;
   logic               w_shift;
   logic               w_finish;
   logic [BCD_W-1:0]   w_adj;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) r_state <= BCD_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         BCD_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = BCD_SHIFT;
            end
         end
         BCD_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == CNT_W'(7)) w_state_nxt = BCD_DONE;
         end
         BCD_DONE: begin
            w_finish    = 1'b1;
            w_state_nxt = BCD_IDLE;
         end
         default: w_state_nxt = BCD_IDLE;
      endcase
   end

   // Add-3 correction on every BCD digit that is 5 or more, ahead of the shift.
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 3; i++) begin
         if (r_bcd[i*NIB_W +: NIB_W] >= NIB_W'(5))
            w_adj[i*NIB_W +: NIB_W] = r_bcd[i*NIB_W +: NIB_W] + NIB_W'(3);
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (w_load) begin
         r_bin  <= binary;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (w_shift) begin
         {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
         r_cnt          <= r_cnt + CNT_W'(1);
      end else if (w_finish) begin
         r_done <= 1'b1;
      end
   end

   assign done     = r_done;
   assign ones     = r_bcd[0 +: NIB_W];
   assign tens     = r_bcd[NIB_W +: NIB_W];
   assign hundreds = r_bcd[2*NIB_W +: NIB_W];

endmodule
`endif

// File: rtl/seven_segment_scanner.sv
// Frame-synchronous value commit and 4-digit multiplexed scan for the seven-segment display.
// Define SEVEN_SEGMENT_BCD_EN for decimal display with leading-zero blanking; default is hex.
module seven_segment_scanner
   import seven_segment_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic               clock,
   input  logic               resetN,
   input  logic [VALUE_W-1:0] value,
   input  logic               valueValid,
   output logic               valueReady,
   output logic [VALUE_W-1:0] leds,
   output logic [SEG_W-1:0]   sevenSegmentData,
   output logic [EN_W-1:0]    sevenSegmentEnable,
   output logic               busy
);

   localparam int unsigned   PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0]      r_presc;
   digit_idx_t         r_idx;
   logic [VALUE_W-1:0] r_shadow;
   logic               r_busy;
   logic               r_ready;
   logic [VALUE_W-1:0] r_leds;
   logic [SEG_W-1:0]   r_seg;
   logic [EN_W-1:0]    r_en;

   logic               w_tick;
   logic               w_boundary;
   logic               w_accept;
   logic               w_result_ok;
   logic               w_commit;
   logic               w_blank;
   logic [SEG_W-1:0]   w_glyph;

   assign w_tick     = (r_presc == PRESC_MAX);
   assign w_boundary = w_tick && (r_idx == 2'd3);
   assign w_accept   = valueValid && r_ready;
   assign w_commit   = r_busy && w_result_ok && w_boundary;

`ifdef SEVEN_SEGMENT_BCD_EN
   logic [NIB_W-1:0] r_ones;
   logic [NIB_W-1:0] r_tens;
   logic [NIB_W-1:0] r_hund;
   logic             w_done;
   logic [NIB_W-1:0] w_ones;
   logic [NIB_W-1:0] w_tens;
   logic [NIB_W-1:0] w_hund;

   binary_to_bcd u_bcd (
      .clock    (clock),
      .resetN   (resetN),
      .start    (w_accept),
      .binary   (value),
      .done     (w_done),
      .ones     (w_ones),
      .tens     (w_tens),
      .hundreds (w_hund)
   );

   assign w_result_ok = w_done;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_ones <= '0;
         r_tens <= '0;
         r_hund <= '0;
      end else if (w_commit) begin
         r_ones <= w_ones;
         r_tens <= w_tens;
         r_hund <= w_hund;
      end
   end

   // Hundreds blank when zero; tens blank only when hundreds is blank too.
   always_comb begin
      w_blank = 1'b1;
      w_glyph = SEG_BLANK;
      case (r_idx)
         2'd0: begin
            w_blank = 1'b0;
            w_glyph = seg_glyph(r_ones);
         end
         2'd1: begin
            w_blank = (r_hund == '0) && (r_tens == '0);
            w_glyph = seg_glyph(r_tens);
         end
         2'd2: begin
            w_blank = (r_hund == '0);
            w_glyph = seg_glyph(r_hund);
         end
         default: ;
      endcase
   end
`else
   logic [VALUE_W-1:0] r_disp;

   // The shadow register is stable from the cycle after capture.
   assign w_result_ok = 1'b1;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN)       r_disp <= '0;
      else if (w_commit) r_disp <= r_shadow;
   end

   always_comb begin
      w_blank = 1'b1;
      w_glyph = SEG_BLANK;
      case (r_idx)
         2'd0: begin
            w_blank = 1'b0;
            w_glyph = seg_glyph(r_disp[3:0]);
         end
         2'd1: begin
            w_blank = 1'b0;
            w_glyph = seg_glyph(r_disp[7:4]);
         end
         default: ;
      endcase
   end
`endif

   // Slot timing, handshake and pin drive; a tick blanks the pins for one cycle before the next digit.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_presc  <= '0;
         r_idx    <= '0;
         r_shadow <= '0;
         r_busy   <= 1'b0;
         r_ready  <= 1'b1;
         r_leds   <= '0;
         r_seg    <= SEG_BLANK;
         r_en     <= ALL_OFF;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) r_idx <= r_idx + 2'd1;

         if (w_accept) begin
            r_shadow <= value;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
         end else if (w_commit) begin
            r_leds  <= r_shadow;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
         end

         r_seg <= (w_tick || w_blank) ? SEG_BLANK : w_glyph;
         r_en  <= (w_tick || w_blank) ? ALL_OFF : digit_enable(r_idx);
      end
   end

   assign valueReady         = r_ready;
   assign busy               = r_busy;
   assign leds               = r_leds;
   assign sevenSegmentData   = r_seg;
   assign sevenSegmentEnable = r_en;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized self-checking bench for seven_segment_scanner at TICK_DIV=4 (16-cycle frame).
// Reference model works from cycle count since reset release; honours SEVEN_SEGMENT_BCD_EN.
module tb_seven_segment_scanner;

   localparam int unsigned TD    = 4;
   localparam int unsigned FRAME = 4 * TD;
`ifdef SEVEN_SEGMENT_BCD_EN
   localparam int READY_LAT = 10;
   localparam int MAX_LAT   = 4 * TD + 10;
`else
   localparam int READY_LAT = 1;
   localparam int MAX_LAT   = 4 * TD + 1;
`endif

   localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   localparam logic [7:0] CVALS  [6]  = '{8'hA5, 8'd7, 8'd255, 8'd0, 8'd100, 8'd99};
   localparam int         CPHASE [6]  = '{0, 6, 5, 2, 9, 12};

   logic       clock;
   logic       resetN;
   logic [7:0] value;
   logic       valueValid;
   logic       valueReady;
   logic [7:0] leds;
   logic [7:0] sevenSegmentData;
   logic [3:0] sevenSegmentEnable;
   logic       busy;

   int         k;
   logic       m_busy;
   logic [7:0] m_pending;
   logic [7:0] m_committed;
   int         m_accept_k;
   int         n_checks;
   int         n_fail;

   seven_segment_scanner #(.TICK_DIV(TD)) dut (
      .clock              (clock),
      .resetN             (resetN),
      .value              (value),
      .valueValid         (valueValid),
      .valueReady         (valueReady),
      .leds               (leds),
      .sevenSegmentData   (sevenSegmentData),
      .sevenSegmentEnable (sevenSegmentEnable),
      .busy               (busy)
   );

   always #5 clock = ~clock;

   // {shown, glyph} for display slot s when committed value c is on the display
   function automatic logic [8:0] slot_view(input int s, input int c);
      logic [3:0] d;
      logic       show;
      show = 1'b0;
      d    = 4'd0;
`ifdef SEVEN_SEGMENT_BCD_EN
      case (s)
         0: begin show = 1'b1;       d = 4'(c % 10);        end
         1: begin show = (c >= 10);  d = 4'((c / 10) % 10); end
         2: begin show = (c >= 100); d = 4'(c / 100);       end
         default: ;
      endcase
`else
      case (s)
         0: begin show = 1'b1; d = 4'(c % 16); end
         1: begin show = 1'b1; d = 4'(c / 16); end
         default: ;
      endcase
`endif
      return {show, GLYPH[d]};
   endfunction

   function automatic logic [3:0] exp_en(input int kk, input int c);
      logic [8:0] v;
      int         s;
      if (kk % TD == 0) return 4'hF;
      s = (kk / TD) % 4;
      v = slot_view(s, c);
      if (!v[8]) return 4'hF;
      return 4'b1111 ^ (4'b0001 << s);
   endfunction

   function automatic logic [7:0] exp_data(input int kk, input int c);
      logic [8:0] v;
      if (kk % TD == 0) return 8'hFF;
      v = slot_view((kk / TD) % 4, c);
      if (!v[8]) return 8'hFF;
      return v[7:0];
   endfunction

   task automatic apply_reset();
      valueValid = 1'b0;
      resetN     = 1'b0;
      @(negedge clock);
      @(negedge clock);
      resetN      = 1'b1;
      k           = 0;
      m_busy      = 1'b0;
      m_pending   = 8'h00;
      m_committed = 8'h00;
      m_accept_k  = 0;
   endtask

   // Drive one cycle (cycle k), update the model at its closing edge, return at the next negedge.
   task automatic advance(input logic v, input logic [7:0] val);
      valueValid = v;
      value      = val;
      @(posedge clock);
      if (v && !m_busy) begin
         m_busy     = 1'b1;
         m_pending  = val;
         m_accept_k = k;
      end else if (m_busy && (k % FRAME == FRAME - 1) && (k >= m_accept_k + READY_LAT)) begin
         m_busy      = 1'b0;
         m_committed = m_pending;
      end
      k++;
      @(negedge clock);
      valueValid = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (sevenSegmentData !== 8'hFF) begin n_fail++; $display("FAIL por_data: got %h want ff", sevenSegmentData); end
      n_checks++; if (sevenSegmentEnable !== 4'hF) begin n_fail++; $display("FAIL por_en: got %b want 1111", sevenSegmentEnable); end
      n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL por_leds: got %h want 00", leds); end
      n_checks++; if (valueReady !== 1'b1) begin n_fail++; $display("FAIL por_ready: got %b want 1", valueReady); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL por_busy: got %b want 0", busy); end
      apply_reset();
      advance(1'b1, 8'h5A);
      for (int w = 0; w < 64 && m_busy; w++) advance(1'b0, 8'h00);
      for (int w = 0; w < 64 && (k % FRAME != 7); w++) advance(1'b0, 8'h00);
      advance(1'b1, 8'hC3);
      repeat (3) advance(1'b0, 8'h00);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
      n_checks++; if (leds !== 8'h5A) begin n_fail++; $display("FAIL pre_reset_leds: got %h want 5a", leds); end
      resetN = 1'b0;
      #1;
      n_checks++; if (sevenSegmentData !== 8'hFF) begin n_fail++; $display("FAIL rst_data: got %h want ff", sevenSegmentData); end
      n_checks++; if (sevenSegmentEnable !== 4'hF) begin n_fail++; $display("FAIL rst_en: got %b want 1111", sevenSegmentEnable); end
      n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL rst_leds: got %h want 00", leds); end
      n_checks++; if (valueReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", valueReady); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      @(posedge clock);
      #1;
      n_checks++; if (sevenSegmentEnable !== 4'hF) begin n_fail++; $display("FAIL rst_edge_en: got %b want 1111", sevenSegmentEnable); end
      apply_reset();
      for (int c = 0; c < 2 * FRAME; c++) begin
         advance(1'b0, 8'h00);
         n_checks++; if (leds !== 8'h00) begin n_fail++; $display("FAIL rst_discard_leds k=%0d: got %h want 00", k, leds); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_discard_busy k=%0d: got %b want 0", k, busy); end
      end
   endtask

   task automatic test_scan_order();
      apply_reset();
      for (int c = 0; c < 2 * FRAME; c++) begin
         advance(1'b0, 8'h00);
         n_checks++; if (sevenSegmentEnable !== exp_en(k, int'(m_committed))) begin n_fail++; $display("FAIL scan_en k=%0d: got %b want %b", k, sevenSegmentEnable, exp_en(k, int'(m_committed))); end
         n_checks++; if (sevenSegmentData !== exp_data(k, int'(m_committed))) begin n_fail++; $display("FAIL scan_data k=%0d: got %h want %h", k, sevenSegmentData, exp_data(k, int'(m_committed))); end
         if (k == 5) begin
            n_checks++; if (sevenSegmentEnable !== 4'b1101) begin n_fail++; $display("FAIL scan_digit1 k=%0d: got %b want 1101", k, sevenSegmentEnable); end
         end
      end
   endtask

   task automatic test_commit();
      for (int i = 0; i < 6; i++) begin
         int acc;
         int obs;
         bit seen;
         for (int w = 0; w < 64 && (m_busy || (k % FRAME != CPHASE[i])); w++) advance(1'b0, 8'h00);
         acc  = k;
         seen = 1'b0;
         obs  = 0;
         advance(1'b1, CVALS[i]);
         for (int w = 0; w < 64 && !seen; w++) begin
            n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL commit_busy v=%h k=%0d: got %b want %b", CVALS[i], k, busy, m_busy); end
            n_checks++; if (valueReady !== !m_busy) begin n_fail++; $display("FAIL commit_ready v=%h k=%0d: got %b want %b", CVALS[i], k, valueReady, !m_busy); end
            if (busy === 1'b0) begin
               seen = 1'b1;
               obs  = k;
            end else begin
               advance(1'b0, 8'h00);
            end
         end
         n_checks++; if (!seen) begin n_fail++; $display("FAIL commit_timeout v=%h: busy got 1 want 0 within 64 cycles", CVALS[i]); end
         if (seen) begin
            n_checks++;
            if ((obs - 1 - acc) < READY_LAT || (obs - 1 - acc) > MAX_LAT) begin
               n_fail++; $display("FAIL commit_latency v=%h: got %0d want %0d..%0d", CVALS[i], obs - 1 - acc, READY_LAT, MAX_LAT);
            end
         end
         n_checks++; if (leds !== CVALS[i]) begin n_fail++; $display("FAIL commit_leds: got %h want %h", leds, CVALS[i]); end
         for (int c = 0; c < FRAME; c++) begin
            advance(1'b0, 8'h00);
            n_checks++; if (sevenSegmentEnable !== exp_en(k, int'(CVALS[i]))) begin n_fail++; $display("FAIL show_en v=%h k=%0d: got %b want %b", CVALS[i], k, sevenSegmentEnable, exp_en(k, int'(CVALS[i]))); end
            n_checks++; if (sevenSegmentData !== exp_data(k, int'(CVALS[i]))) begin n_fail++; $display("FAIL show_data v=%h k=%0d: got %h want %h", CVALS[i], k, sevenSegmentData, exp_data(k, int'(CVALS[i]))); end
         end
      end
   endtask

   task automatic test_backpressure();
      for (int w = 0; w < 64 && m_busy; w++) advance(1'b0, 8'h00);
      advance(1'b1, 8'h3C);
      for (int w = 0; w < 64 && m_busy; w++) begin
         advance(1'b1, 8'h11);
         n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL bp_busy k=%0d: got %b want %b", k, busy, m_busy); end
         n_checks++; if (leds !== m_committed) begin n_fail++; $display("FAIL bp_leds k=%0d: got %h want %h", k, leds, m_committed); end
      end
      n_checks++; if (leds !== 8'h3C) begin n_fail++; $display("FAIL bp_first: got %h want 3c", leds); end
      advance(1'b1, 8'h11);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_after: got %b want 1", busy); end
      for (int w = 0; w < 64 && m_busy; w++) advance(1'b0, 8'h00);
      n_checks++; if (leds !== 8'h11) begin n_fail++; $display("FAIL bp_second: got %h want 11", leds); end
   endtask

   task automatic test_boundary_capture();
      logic [7:0] prev;
      for (int w = 0; w < 64 && (m_busy || (k % FRAME != FRAME - 1)); w++) advance(1'b0, 8'h00);
      prev = m_committed;
      advance(1'b1, 8'h66);
      for (int c = 1; c <= FRAME; c++) begin
         advance(1'b0, 8'h00);
         n_checks++; if (leds !== ((c == FRAME) ? 8'h66 : prev)) begin n_fail++; $display("FAIL bnd_leds c=%0d: got %h want %h", c, leds, (c == FRAME) ? 8'h66 : prev); end
         n_checks++; if (busy !== 1'(c < FRAME)) begin n_fail++; $display("FAIL bnd_busy c=%0d: got %b want %b", c, busy, 1'(c < FRAME)); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         advance(1'($urandom_range(0, 7) == 0), 8'($urandom));
         n_checks++; if (sevenSegmentEnable !== exp_en(k, int'(m_committed))) begin n_fail++; $display("FAIL rnd_en k=%0d: got %b want %b", k, sevenSegmentEnable, exp_en(k, int'(m_committed))); end
         n_checks++; if (sevenSegmentData !== exp_data(k, int'(m_committed))) begin n_fail++; $display("FAIL rnd_data k=%0d: got %h want %h", k, sevenSegmentData, exp_data(k, int'(m_committed))); end
         n_checks++; if (leds !== m_committed) begin n_fail++; $display("FAIL rnd_leds k=%0d: got %h want %h", k, leds, m_committed); end
         n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy k=%0d: got %b want %b", k, busy, m_busy); end
         n_checks++; if (valueReady !== !m_busy) begin n_fail++; $display("FAIL rnd_ready k=%0d: got %b want %b", k, valueReady, !m_busy); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clock       = 1'b0;
      resetN      = 1'b0;
      valueValid  = 1'b0;
      value       = 8'h00;
      k           = 0;
      m_busy      = 1'b0;
      m_pending   = 8'h00;
      m_committed = 8'h00;
      m_accept_k  = 0;
      n_checks    = 0;
      n_fail      = 0;
      repeat (3) @(negedge clock);
      test_reset();
      test_scan_order();
      test_commit();
      test_backpressure();
      test_boundary_capture();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
